// File: rtl/iram_ctrl_pkg.sv
// Shared definitions for the instruction RAM controller: word width, NOP word, FSM states.
// Optional stored parity is enabled with IRAM_PARITY_EN.
package iram_ctrl_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      StRun    = 2'd0,
      StLoad   = 2'd1,
      StCommit = 2'd2
   } iram_state_e;

   // Bit that makes {bit, word} have even parity.
   function automatic logic even_par(input logic [XLEN-1:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/iram_dp_mem.sv
// 1R1W synchronous word array with registered read port; contents are not reset.
// Width is chosen by the instantiating controller (32 bits, or 33 with IRAM_PARITY_EN).
module iram_dp_mem #(
   parameter int unsigned AW = 12,
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata_q <= mem[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/iram_ctrl.sv
// Instruction RAM controller: serves IF-stage fetches and packs a loader byte stream into words.
// Define IRAM_PARITY_EN to store even parity per word and flag mismatches on inst_perr.
module iram_ctrl
   import iram_ctrl_pkg::*;
#(
   parameter int unsigned     IRAM_AW  = 12,
   parameter logic [XLEN-1:0] NOP_INST = INST_NOP
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            iram_en,
   input  logic [XLEN-3:0] inst_raddr,
   output logic [XLEN-1:0] inst,
   output logic            inst_perr,
   input  logic            ld_start,
   input  logic            ld_valid,
   output logic            ld_ready,
   input  logic [7:0]      ld_byte,
   input  logic            ld_last,
   output logic            ld_done,
   output logic            ld_ovf,
   output logic            cpu_hold
);

`ifdef IRAM_PARITY_EN
   localparam int unsigned MemW = XLEN + 1;
`else
   localparam int unsigned MemW = XLEN;
`endif

   iram_state_e     state_q, state_d;
   // MSB set means the array end was passed; further words are dropped.
   logic [IRAM_AW:0] wr_addr_q, wr_addr_d;
   logic [1:0]      byte_cnt_q, byte_cnt_d;
   logic [XLEN-1:0] word_q, word_d;
   logic            ovf_q, ovf_d;
   logic            nop_q, nop_d;

   logic            accept, word_done, mem_we, mem_re;
   logic [XLEN-1:0] word_next;
   logic [MemW-1:0] mem_wdata, mem_rdata;
   logic            unused_raddr;

   assign accept    = (state_q == StLoad) && ld_valid;
   // Upper bytes of word_q are still zero, so a short final word pads with zeros.
   assign word_next = word_q | ({24'b0, ld_byte} << {byte_cnt_q, 3'b000});
   assign word_done = accept && ((byte_cnt_q == 2'd3) || ld_last);
   assign mem_we    = word_done && !wr_addr_q[IRAM_AW];
   assign mem_re    = (state_q == StRun) && iram_en;

   assign unused_raddr = ^inst_raddr[XLEN-3:IRAM_AW];

   always_comb begin
      state_d    = state_q;
      wr_addr_d  = wr_addr_q;
      byte_cnt_d = byte_cnt_q;
      word_d     = word_q;
      ovf_d      = ovf_q;
      nop_d      = nop_q;
      unique case (state_q)
         StRun: begin
            if (iram_en) nop_d = 1'b0;
            if (ld_start) begin
               state_d    = StLoad;
               wr_addr_d  = '0;
               byte_cnt_d = '0;
               word_d     = '0;
               ovf_d      = 1'b0;
            end
         end
         StLoad: begin
            if (iram_en) nop_d = 1'b1;
            if (accept) begin
               if (word_done) begin
                  byte_cnt_d = '0;
                  word_d     = '0;
                  if (wr_addr_q[IRAM_AW]) ovf_d = 1'b1;
                  else                    wr_addr_d = wr_addr_q + 1'b1;
               end else begin
                  byte_cnt_d = byte_cnt_q + 2'd1;
                  word_d     = word_next;
               end
               if (ld_last) state_d = StCommit;
            end
         end
         StCommit: begin
            if (iram_en) nop_d = 1'b1;
            state_d = StRun;
         end
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StRun;
         wr_addr_q  <= '0;
         byte_cnt_q <= '0;
         word_q     <= '0;
         ovf_q      <= 1'b0;
         nop_q      <= 1'b1;
      end else begin
         state_q    <= state_d;
         wr_addr_q  <= wr_addr_d;
         byte_cnt_q <= byte_cnt_d;
         word_q     <= word_d;
         ovf_q      <= ovf_d;
         nop_q      <= nop_d;
      end
   end

   iram_dp_mem #(
      .AW(IRAM_AW),
      .DW(MemW)
   ) u_mem (
      .clk  (clk),
      .we   (mem_we),
      .waddr(wr_addr_q[IRAM_AW-1:0]),
      .wdata(mem_wdata),
      .re   (mem_re),
      .raddr(inst_raddr[IRAM_AW-1:0]),
      .rdata(mem_rdata)
   );

`ifdef IRAM_PARITY_EN
   assign mem_wdata = {even_par(word_next), word_next};
   assign inst_perr = !nop_q && (^mem_rdata);
`else
   assign mem_wdata = word_next;
   assign inst_perr = 1'b0;
`endif

   assign inst     = nop_q ? NOP_INST : mem_rdata[XLEN-1:0];
   assign ld_ready = (state_q == StLoad);
   assign ld_done  = (state_q == StCommit);
   assign ld_ovf   = ovf_q;
   assign cpu_hold = (state_q != StRun);

endmodule
